// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results through to writeback, runs a
// req/ack data-memory transaction for loads and stores (stalling upstream
// while it waits), and flags misaligned accesses and memory timeouts.
module mem_stage #(
  parameter int TIMEOUT        = 16,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ex_valid,
  input  logic [31:0]               ex_result,
  input  logic [31:0]               ex_store_data,
  input  logic [31:0]               ex_next_pc,
  input  logic [2:0]                ex_flag,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_reg_write,
  output logic                      stall,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [31:0]               dmem_addr,
  output logic [31:0]               dmem_wdata,
  input  logic [31:0]               dmem_rdata,
  input  logic                      dmem_ack,
  output logic                      wb_valid,
  output logic [31:0]               wb_data,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      wb_reg_write,
  output logic [31:0]               wb_next_pc,
  output logic [2:0]                wb_flag,
  output logic                      mem_fault
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             counter_q, counter_d;
  logic [31:0]               addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      we_q, we_d;
  logic                      regw_q, regw_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [31:0]               npc_q, npc_d;
  logic [2:0]                flag_q, flag_d;
  logic                      wbValid_q, wbValid_d;
  logic [31:0]               wbData_q, wbData_d;
  logic [REG_ADDR_WIDTH-1:0] wbRd_q, wbRd_d;
  logic                      wbRegWrite_q, wbRegWrite_d;
  logic [31:0]               wbNextPc_q, wbNextPc_d;
  logic [2:0]                wbFlag_q, wbFlag_d;
  logic                      fault_q, fault_d;

  logic memop;
  logic misaligned;
  logic timeoutNow;

  assign memop      = ex_mem_read | ex_mem_write;
  assign misaligned = (ex_result[1:0] != 2'b00);
  assign timeoutNow = (counter_q == CW'(TIMEOUT - 1));

  // Next-state, latch and writeback selection; wb_valid/mem_fault default low so they pulse
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    regw_d       = regw_q;
    rd_d         = rd_q;
    npc_d        = npc_q;
    flag_d       = flag_q;
    wbValid_d    = 1'b0;
    wbData_d     = wbData_q;
    wbRd_d       = wbRd_q;
    wbRegWrite_d = wbRegWrite_q;
    wbNextPc_d   = wbNextPc_q;
    wbFlag_d     = wbFlag_q;
    fault_d      = 1'b0;
    stall        = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!memop) begin
            wbValid_d    = 1'b1;
            wbData_d     = ex_result;
            wbRd_d       = ex_rd;
            wbRegWrite_d = ex_reg_write;
            wbNextPc_d   = ex_next_pc;
            wbFlag_d     = ex_flag;
          end else if (misaligned) begin
            wbValid_d    = 1'b1;
            fault_d      = 1'b1;
            wbData_d     = 32'h0;
            wbRd_d       = ex_rd;
            wbRegWrite_d = 1'b0;
            wbNextPc_d   = ex_next_pc;
            wbFlag_d     = ex_flag;
          end else begin
            stall     = 1'b1;
            addr_d    = ex_result;
            wdata_d   = ex_store_data;
            we_d      = ex_mem_write;
            regw_d    = ex_reg_write;
            rd_d      = ex_rd;
            npc_d     = ex_next_pc;
            flag_d    = ex_flag;
            counter_d = '0;
            state_d   = ACCESS;
          end
        end
      end
      ACCESS: begin
        stall     = !(dmem_ack | timeoutNow);
        counter_d = counter_q + CW'(1);
        if (dmem_ack) begin
          state_d      = IDLE;
          counter_d    = '0;
          wbValid_d    = 1'b1;
          wbData_d     = we_q ? addr_q : dmem_rdata;
          wbRd_d       = rd_q;
          wbRegWrite_d = regw_q & !we_q;
          wbNextPc_d   = npc_q;
          wbFlag_d     = flag_q;
        end else if (timeoutNow) begin
          state_d      = IDLE;
          counter_d    = '0;
          wbValid_d    = 1'b1;
          fault_d      = 1'b1;
          wbData_d     = 32'h0;
          wbRd_d       = rd_q;
          wbRegWrite_d = 1'b0;
          wbNextPc_d   = npc_q;
          wbFlag_d     = flag_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      we_q         <= 1'b0;
      regw_q       <= 1'b0;
      rd_q         <= '0;
      npc_q        <= 32'h0;
      flag_q       <= 3'h0;
      wbValid_q    <= 1'b0;
      wbData_q     <= 32'h0;
      wbRd_q       <= '0;
      wbRegWrite_q <= 1'b0;
      wbNextPc_q   <= 32'h0;
      wbFlag_q     <= 3'h0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      regw_q       <= regw_d;
      rd_q         <= rd_d;
      npc_q        <= npc_d;
      flag_q       <= flag_d;
      wbValid_q    <= wbValid_d;
      wbData_q     <= wbData_d;
      wbRd_q       <= wbRd_d;
      wbRegWrite_q <= wbRegWrite_d;
      wbNextPc_q   <= wbNextPc_d;
      wbFlag_q     <= wbFlag_d;
      fault_q      <= fault_d;
    end
  end

  assign dmem_req     = (state_q == ACCESS);
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = wbValid_q;
  assign wb_data      = wbData_q;
  assign wb_rd        = wbRd_q;
  assign wb_reg_write = wbRegWrite_q;
  assign wb_next_pc   = wbNextPc_q;
  assign wb_flag      = wbFlag_q;
  assign mem_fault    = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: drives instructions, acts as the data memory with a
// chosen ack delay, and checks results against a transaction-level model.
module tb_mem_stage;

  localparam int TIMEOUT = 16;
  localparam int RW      = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid;
  logic [31:0]   ex_result;
  logic [31:0]   ex_store_data;
  logic [31:0]   ex_next_pc;
  logic [2:0]    ex_flag;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write;
  logic          stall;
  logic          dmem_req;
  logic          dmem_we;
  logic [31:0]   dmem_addr;
  logic [31:0]   dmem_wdata;
  logic [31:0]   dmem_rdata;
  logic          dmem_ack;
  logic          wb_valid;
  logic [31:0]   wb_data;
  logic [RW-1:0] wb_rd;
  logic          wb_reg_write;
  logic [31:0]   wb_next_pc;
  logic [2:0]    wb_flag;
  logic          mem_fault;

  int total = 0;
  int bad   = 0;

  logic [31:0] refMem   [int unsigned];
  logic [31:0] benchMem [int unsigned];

  logic [31:0]   expData;
  logic [RW-1:0] expRd;
  logic          expRegw;
  logic [31:0]   expNpc;
  logic [2:0]    expFlag;

  mem_stage #(.TIMEOUT(TIMEOUT), .REG_ADDR_WIDTH(RW)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_next_pc(ex_next_pc), .ex_flag(ex_flag), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_next_pc(wb_next_pc), .wb_flag(wb_flag),
    .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  // One instruction through the stage. Called at posedge+1; returns at
  // posedge+1 of the cycle where its writeback fields are visible.
  // ackDelay = ACCESS cycle on which memory acks (> TIMEOUT means never).
  task automatic runInstr(input logic isLoad, input logic isStore,
                          input logic [31:0] res, input logic [31:0] sdata,
                          input logic [31:0] npc, input logic [2:0] flg,
                          input logic [RW-1:0] rd, input logic regw,
                          input int ackDelay, input string tag);
    logic memop;
    logic mis;
    logic acked;
    logic done;
    logic [31:0] loadVal;
    logic [31:0] eData;
    logic eRegw;
    logic eFault;
    memop = isLoad | isStore;
    mis   = (res[1:0] != 2'b00);
    ex_valid = 1'b1; ex_result = res; ex_store_data = sdata; ex_next_pc = npc;
    ex_flag = flg; ex_mem_read = isLoad; ex_mem_write = isStore;
    ex_rd = rd; ex_reg_write = regw;
    #1;
    total++;
    if (stall !== (memop && !mis)) begin
      bad++; $display("[TB] FAIL %s issue_stall got=%b exp=%b", tag, stall, memop && !mis);
    end
    acked = 1'b0;
    if (!memop || mis) begin
      @(posedge clk); #1;
      eData  = memop ? 32'h0 : res;
      eRegw  = memop ? 1'b0 : regw;
      eFault = memop;
    end else begin
      @(posedge clk); #1;
      done = 1'b0;
      for (int k = 1; k <= TIMEOUT && !done; k++) begin
        total++;
        if (dmem_req !== 1'b1 || dmem_addr !== res || dmem_we !== isStore) begin
          bad++; $display("[TB] FAIL %s access_c%0d req=%b addr=%h we=%b exp req=1 addr=%h we=%b",
                          tag, k, dmem_req, dmem_addr, dmem_we, res, isStore);
        end
        if (isStore) begin
          total++;
          if (dmem_wdata !== sdata) begin
            bad++; $display("[TB] FAIL %s wdata got=%h exp=%h", tag, dmem_wdata, sdata);
          end
        end
        total++;
        if (wb_valid !== 1'b0) begin
          bad++; $display("[TB] FAIL %s wb_valid_during_access got=%b exp=0", tag, wb_valid);
        end
        if (k == ackDelay) begin
          dmem_ack   = 1'b1;
          dmem_rdata = benchMem.exists(dmem_addr) ? benchMem[dmem_addr] : 32'h0;
          if (dmem_we) benchMem[dmem_addr] = dmem_wdata;
          acked = 1'b1;
          done  = 1'b1;
        end else if (k == TIMEOUT) begin
          done = 1'b1;
        end
        #1;
        total++;
        if (stall !== !done) begin
          bad++; $display("[TB] FAIL %s access_stall_c%0d got=%b exp=%b", tag, k, stall, !done);
        end
        @(posedge clk); #1;
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
      end
      loadVal = refMem.exists(res) ? refMem[res] : 32'h0;
      if (acked) begin
        eData  = isStore ? res : loadVal;
        eRegw  = regw & !isStore;
        eFault = 1'b0;
        if (isStore) refMem[res] = sdata;
      end else begin
        eData  = 32'h0;
        eRegw  = 1'b0;
        eFault = 1'b1;
      end
    end
    total++;
    if (wb_valid !== 1'b1 || mem_fault !== eFault || dmem_req !== 1'b0) begin
      bad++; $display("[TB] FAIL %s wb_strobe valid=%b fault=%b req=%b exp valid=1 fault=%b req=0",
                      tag, wb_valid, mem_fault, dmem_req, eFault);
    end
    total++;
    if (wb_data !== eData || wb_reg_write !== eRegw || wb_rd !== rd) begin
      bad++; $display("[TB] FAIL %s wb_fields data=%h regw=%b rd=%0d exp data=%h regw=%b rd=%0d",
                      tag, wb_data, wb_reg_write, wb_rd, eData, eRegw, rd);
    end
    total++;
    if (wb_next_pc !== npc || wb_flag !== flg) begin
      bad++; $display("[TB] FAIL %s wb_pass npc=%h flag=%b exp npc=%h flag=%b",
                      tag, wb_next_pc, wb_flag, npc, flg);
    end
    expData = eData; expRegw = eRegw; expRd = rd; expNpc = npc; expFlag = flg;
    ex_valid = 1'b0;
  endtask

  // Idle cycles with random garbage on ex_* and optional stray acks
  task automatic idleCycles(input int n, input logic strayAck);
    for (int i = 0; i < n; i++) begin
      ex_valid = 1'b0; ex_result = $urandom; ex_mem_read = 1'($urandom);
      ex_mem_write = 1'($urandom); ex_rd = RW'($urandom);
      dmem_ack = strayAck ? 1'($urandom) : 1'b0; dmem_rdata = $urandom;
      #1;
      total++;
      if (stall !== 1'b0) begin
        bad++; $display("[TB] FAIL idle_stall got=%b exp=0", stall);
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      total++;
      if (wb_valid !== 1'b0 || mem_fault !== 1'b0 || dmem_req !== 1'b0) begin
        bad++; $display("[TB] FAIL idle_strobes valid=%b fault=%b req=%b exp 0/0/0",
                        wb_valid, mem_fault, dmem_req);
      end
      total++;
      if (wb_data !== expData || wb_rd !== expRd || wb_reg_write !== expRegw ||
          wb_next_pc !== expNpc || wb_flag !== expFlag) begin
        bad++; $display("[TB] FAIL idle_hold data=%h rd=%0d regw=%b npc=%h flag=%b exp %h %0d %b %h %b",
                        wb_data, wb_rd, wb_reg_write, wb_next_pc, wb_flag,
                        expData, expRd, expRegw, expNpc, expFlag);
      end
    end
  endtask

  // Reset clears every registered output
  task automatic test_reset();
    reset = 1'b0; ex_valid = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    ex_result = 32'h0; ex_store_data = 32'h0; ex_next_pc = 32'h0; ex_flag = 3'h0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_rd = '0; ex_reg_write = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (wb_valid !== 1'b0 || mem_fault !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 ||
        dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_ctrl valid=%b fault=%b req=%b we=%b addr=%h wdata=%h exp all 0",
                      wb_valid, mem_fault, dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    total++;
    if (wb_data !== 32'h0 || wb_rd !== '0 || wb_reg_write !== 1'b0 ||
        wb_next_pc !== 32'h0 || wb_flag !== 3'h0) begin
      bad++; $display("[TB] FAIL reset_wb data=%h rd=%0d regw=%b npc=%h flag=%b exp all 0",
                      wb_data, wb_rd, wb_reg_write, wb_next_pc, wb_flag);
    end
    expData = 32'h0; expRd = '0; expRegw = 1'b0; expNpc = 32'h0; expFlag = 3'h0;
    dmem_ack = 1'b0;
    reset = 1'b1;
    idleCycles(2, 1'b1);
  endtask

  // ALU pass-through, then four back-to-back issues
  task automatic test_alu_passthrough();
    runInstr(1'b0, 1'b0, 32'h0000_0042, 32'h0, 32'h0000_1004, 3'b010, 5'd3, 1'b1, 0, "alu");
    idleCycles(1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      runInstr(1'b0, 1'b0, 32'h100 + 32'(i), 32'h0, 32'h2000 + 32'(4 * i), 3'(i),
               RW'(i + 7), 1'(i % 2), 0, "b2b");
    idleCycles(1, 1'b0);
  endtask

  // Store DEADBEEF then load it back with ack on the 3rd ACCESS cycle
  task automatic test_load();
    runInstr(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h3000, 3'b001, 5'd9, 1'b0, 1, "preload");
    runInstr(1'b1, 1'b0, 32'h100, 32'h0, 32'h3004, 3'b100, 5'd5, 1'b1, 3, "load");
    idleCycles(1, 1'b0);
  endtask

  // Store with immediate ack, and a read+write that must behave as a store
  task automatic test_store();
    runInstr(1'b0, 1'b1, 32'h200, 32'h1234_5678, 32'h4000, 3'b011, 5'd6, 1'b1, 1, "store");
    runInstr(1'b1, 1'b1, 32'h204, 32'hCAFE_F00D, 32'h4004, 3'b110, 5'd7, 1'b1, 2, "rdwr");
    runInstr(1'b1, 1'b0, 32'h204, 32'h0, 32'h4008, 3'b000, 5'd8, 1'b1, 1, "load_rdwr");
    idleCycles(1, 1'b0);
  endtask

  task automatic test_misaligned();
    runInstr(1'b1, 1'b0, 32'h103, 32'h0, 32'h5000, 3'b101, 5'd4, 1'b1, 1, "misaligned");
    runInstr(1'b0, 1'b1, 32'h202, 32'h5555_AAAA, 32'h5004, 3'b111, 5'd2, 1'b0, 1, "mis_store");
    idleCycles(1, 1'b0);
  endtask

  // No ack faults after TIMEOUT cycles; ack on the last cycle does not
  task automatic test_timeout();
    runInstr(1'b1, 1'b0, 32'h300, 32'h0, 32'h6000, 3'b010, 5'd11, 1'b1, TIMEOUT + 5, "timeout");
    runInstr(1'b1, 1'b0, 32'h100, 32'h0, 32'h6004, 3'b001, 5'd12, 1'b1, TIMEOUT, "ack_at_limit");
    idleCycles(1, 1'b0);
  endtask

  // Reset on the 2nd ACCESS cycle, then a late ack must be ignored
  task automatic test_reset_mid_access();
    ex_valid = 1'b1; ex_result = 32'h40; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_rd = 5'd13; ex_reg_write = 1'b1; ex_next_pc = 32'h7000; ex_flag = 3'b011;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (dmem_req !== 1'b1) begin
      bad++; $display("[TB] FAIL rst_mid_req_before got=%b exp=1", dmem_req);
    end
    reset = 1'b0; ex_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b0 || wb_data !== 32'h0) begin
      bad++; $display("[TB] FAIL rst_mid_after req=%b valid=%b stall=%b data=%h exp 0/0/0/0",
                      dmem_req, wb_valid, stall, wb_data);
    end
    reset = 1'b1;
    expData = 32'h0; expRd = '0; expRegw = 1'b0; expNpc = 32'h0; expFlag = 3'h0;
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    total++;
    if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_late_ack valid=%b req=%b exp 0/0", wb_valid, dmem_req);
    end
    idleCycles(2, 1'b0);
  endtask

  // Random mix of ALU ops, loads, stores, misalignment and slow memory
  task automatic test_random();
    int kind;
    int delay;
    logic [31:0] addr;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      addr = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) delay = $urandom_range(1, TIMEOUT + 2);
      else delay = $urandom_range(1, 4);
      if (kind == 0) addr = $urandom;
      runInstr(kind == 1 || kind == 3, kind == 2 || kind == 3, addr, $urandom, $urandom,
               3'($urandom), RW'($urandom), 1'($urandom), delay, "random");
      idleCycles($urandom_range(0, 2), 1'b1);
    end
  endtask

  initial begin
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    test_reset();
    test_alu_passthrough();
    test_back_to_back();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
